// File: rtl/slicer_16_qam.sv
// rtl/slicer_16_qam.sv - 16-QAM slicer with amplitude-calibrated threshold and windowed symbol-error count
module slicer_16_qam #(
    parameter logic signed [17:0] LEVEL_A   = 18'sd32768,
    parameter int                 REF_DELAY = 2,
    parameter int                 AVG_LOG2  = 8,
    parameter int                 WIN_LOG2  = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sym_clk_en,
    input  logic signed [17:0]       in_phs_sig,
    input  logic signed [17:0]       quad_sig,
    input  logic [3:0]               ref_sym,
    input  logic                     recal,
    output logic [3:0]               sym_out,
    output logic                     sym_valid,
    output logic [17:0]              threshold,
    output logic                     cal_done,
    output logic [WIN_LOG2:0]        err_count,
    output logic                     err_valid
);
    localparam int ACC_W = 18 + AVG_LOG2 + 1;

    typedef enum logic {CAL, RUN} state_t;
    state_t state, state_next;

    logic [ACC_W-1:0]    acc, acc_next;
    logic [AVG_LOG2-1:0] cal_cnt;
    logic [WIN_LOG2-1:0] win_cnt;
    logic [WIN_LOG2:0]   err_acc, err_next;
    logic [3:0]          dly [REF_DELAY];
    logic [3:0]          slice_now;
    logic [17:0]         thr_raw;
    logic                sym_err;

    // Zero and exact +T land on the positive side; exact -T lands on the inner negative level.
    function automatic logic [1:0] slice_dim(input logic signed [17:0] x, input logic [17:0] t);
        logic signed [18:0] xs;
        logic signed [18:0] ts;
        xs = {x[17], x};
        ts = {1'b0, t};
        if (xs >= ts)
            return 2'b10;
        else if (!x[17])
            return 2'b11;
        else if (xs >= -ts)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    function automatic logic [17:0] mag(input logic signed [17:0] x);
        if (x == {1'b1, 17'd0})
            return 18'd131071;
        else if (x[17])
            return $unsigned(-x);
        else
            return $unsigned(x);
    endfunction

    assign slice_now = {slice_dim(in_phs_sig, threshold), slice_dim(quad_sig, threshold)};
    assign sym_err   = (slice_now != dly[REF_DELAY-1]);
    assign acc_next  = acc + ACC_W'(mag(in_phs_sig)) + ACC_W'(mag(quad_sig));
    // Dividing by 2^(AVG_LOG2+1) turns the |I|+|Q| sum into the mean per-dimension magnitude.
    assign thr_raw   = acc_next[ACC_W-1:AVG_LOG2+1];
    assign err_next  = err_acc + (WIN_LOG2+1)'(sym_err);

    always_ff @(posedge clk) begin
        if (reset)
            state <= CAL;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (recal) begin
            state_next = CAL;
        end else if (sym_clk_en) begin
            case (state)
                CAL:     if (cal_cnt == '1) state_next = RUN;
                RUN:     state_next = RUN;
                default: state_next = CAL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sym_out   <= 4'd0;
            sym_valid <= 1'b0;
            threshold <= {LEVEL_A[16:0], 1'b0};
            cal_done  <= 1'b0;
            err_count <= '0;
            err_valid <= 1'b0;
            acc       <= '0;
            cal_cnt   <= '0;
            win_cnt   <= '0;
            err_acc   <= '0;
            for (int k = 0; k < REF_DELAY; k++)
                dly[k] <= 4'd0;
        end else begin
            sym_valid <= 1'b0;
            err_valid <= 1'b0;
            if (sym_clk_en) begin
                sym_out   <= slice_now;
                sym_valid <= 1'b1;
                dly[0]    <= ref_sym;
                for (int k = 1; k < REF_DELAY; k++)
                    dly[k] <= dly[k-1];
            end
            if (recal) begin
                acc      <= '0;
                cal_cnt  <= '0;
                win_cnt  <= '0;
                err_acc  <= '0;
                cal_done <= 1'b0;
            end else if (sym_clk_en) begin
                if (state == CAL) begin
                    if (cal_cnt == '1) begin
                        threshold <= (thr_raw == 18'd0) ? 18'd1 : thr_raw;
                        acc       <= '0;
                        cal_cnt   <= '0;
                        cal_done  <= 1'b1;
                    end else begin
                        acc     <= acc_next;
                        cal_cnt <= cal_cnt + 1'b1;
                    end
                end else begin
                    if (win_cnt == '1) begin
                        err_count <= err_next;
                        err_valid <= 1'b1;
                        err_acc   <= '0;
                        win_cnt   <= '0;
                    end else begin
                        err_acc <= err_next;
                        win_cnt <= win_cnt + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_slicer_16_qam.sv
// tb/tb_slicer_16_qam.sv - randomized loopback bench for slicer_16_qam against an arithmetic reference model
module tb_slicer_16_qam;
    localparam int REF_DELAY = 2;

    logic              clk = 1'b0;
    logic              reset, sym_clk_en, recal;
    logic signed [17:0] in_phs_sig, quad_sig;
    logic [3:0]        ref_sym, sym_out;
    logic              sym_valid, cal_done, err_valid;
    logic [17:0]       threshold;
    logic [10:0]       err_count;

    slicer_16_qam dut (
        .clk(clk), .reset(reset), .sym_clk_en(sym_clk_en),
        .in_phs_sig(in_phs_sig), .quad_sig(quad_sig), .ref_sym(ref_sym), .recal(recal),
        .sym_out(sym_out), .sym_valid(sym_valid), .threshold(threshold), .cal_done(cal_done),
        .err_count(err_count), .err_valid(err_valid)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;

    // Reference model state
    int         m_thr, m_cnt, m_win, m_err, m_errcnt;
    longint     m_acc;
    bit         m_cal, exp_ev;
    logic [3:0] exp_sym;
    logic [3:0] m_dl[$];

    // Stimulus generator state: pipe holds symbols already announced on ref_sym but not yet transmitted
    logic [3:0] pipe[$];
    int seq_ctr = 0, sym_idx = 0, scale_sh = 0, inv_every = 0;
    bit seq_mode = 0;

    function automatic logic [1:0] ref_slice(input int x, input int t);
        if (x >= t) return 2'b10;
        if (x >= 0) return 2'b11;
        if (x >= -t) return 2'b01;
        return 2'b00;
    endfunction

    function automatic int ref_mag(input int x);
        int a;
        a = (x < 0) ? -x : x;
        return (a > 131071) ? 131071 : a;
    endfunction

    function automatic int lvl(input logic [1:0] b);
        int a;
        a = 32768 >> scale_sh;
        case (b)
            2'b00:   return -3 * a;
            2'b01:   return -a;
            2'b11:   return a;
            default: return 3 * a;
        endcase
    endfunction

    function automatic logic [3:0] next_sym();
        logic [3:0] s;
        s = seq_mode ? 4'(seq_ctr) : 4'($urandom_range(0, 15));
        seq_ctr++;
        return s;
    endfunction

    task automatic gen(output logic signed [17:0] i, output logic signed [17:0] q, output logic [3:0] r);
        logic [3:0] s, sent;
        s = next_sym();
        sent = pipe.pop_front();
        pipe.push_back(s);
        r = s;
        i = 18'(lvl(sent[3:2]));
        q = 18'(lvl(sent[1:0]));
        if (inv_every != 0 && sym_idx % inv_every == 0) i = -i;
        sym_idx++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; sym_clk_en = 0; recal = 0;
        in_phs_sig = 18'($urandom); quad_sig = 18'($urandom); ref_sym = 4'($urandom);
        repeat (3) @(negedge clk);
        reset = 0;
        m_thr = 65536; m_cnt = 0; m_win = 0; m_err = 0; m_errcnt = 0; m_acc = 0;
        m_cal = 0; exp_ev = 0; exp_sym = 4'd0;
        m_dl.delete();
        for (int k = 0; k < REF_DELAY; k++) m_dl.push_back(4'd0);
        seq_ctr = 0; sym_idx = 0;
        pipe.delete();
        for (int k = 0; k < REF_DELAY; k++) pipe.push_back(next_sym());
    endtask

    // Drives one enabled symbol and advances the model; outputs are sampled 1 ns after the edge.
    task automatic step(input logic signed [17:0] i, input logic signed [17:0] q,
                        input logic [3:0] r, input bit rc);
        bit e;
        int t;
        repeat ($urandom_range(0, 1)) @(negedge clk);
        exp_sym = {ref_slice(int'(i), m_thr), ref_slice(int'(q), m_thr)};
        e = (exp_sym != m_dl[0]);
        exp_ev = 0;
        if (rc) begin
            m_cal = 0; m_cnt = 0; m_acc = 0; m_win = 0; m_err = 0;
        end else if (!m_cal) begin
            m_acc += ref_mag(int'(i)) + ref_mag(int'(q));
            m_cnt++;
            if (m_cnt == 256) begin
                t = int'(m_acc / 512);
                m_thr = (t < 1) ? 1 : t;
                m_cal = 1; m_cnt = 0; m_acc = 0;
            end
        end else begin
            m_win++;
            m_err += int'(e);
            if (m_win == 1024) begin
                m_errcnt = m_err; exp_ev = 1; m_win = 0; m_err = 0;
            end
        end
        void'(m_dl.pop_front());
        m_dl.push_back(r);
        @(negedge clk);
        sym_clk_en = 1; in_phs_sig = i; quad_sig = q; ref_sym = r; recal = rc;
        @(posedge clk);
        #1;
        sym_clk_en = 0; recal = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_vec++;
        if (threshold !== 18'd65536 || sym_out !== 4'd0 || cal_done !== 1'b0 ||
            err_count !== 11'd0 || sym_valid !== 1'b0 || err_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset: thr=%0d sym=%h cal=%b cnt=%0d sv=%b ev=%b, want 65536 0 0 0 0 0",
                     threshold, sym_out, cal_done, err_count, sym_valid, err_valid);
        end
    endtask

    task automatic test_boundary();
        int         iv [7] = '{65536, 65535, 0, -1, -65536, -65537, -131072};
        logic [1:0] ev [7] = '{2'b10, 2'b11, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00};
        for (int k = 0; k < 7; k++) begin
            step(18'(iv[k]), 18'($urandom), 4'($urandom), 1'b0);
            n_vec++;
            if (sym_out[3:2] !== ev[k] || sym_out !== exp_sym || sym_valid !== 1'b1) begin
                n_err++;
                $display("FAIL boundary I=%0d: sym=%b valid=%b, want I bits %b sym %b valid 1",
                         iv[k], sym_out, sym_valid, ev[k], exp_sym);
            end
        end
    endtask

    // Calibrates on a balanced sequence, then runs random windows; checks threshold and every err_valid.
    task automatic run_loopback(input string name, input int want_thr, input int n_run);
        logic signed [17:0] i, q;
        logic [3:0] r;
        int wins;
        seq_mode = 1;
        do_reset();
        for (int n = 0; n < 256; n++) begin
            gen(i, q, r);
            step(i, q, r, 1'b0);
            n_vec++;
            if (sym_out !== exp_sym || sym_valid !== 1'b1 || err_valid !== 1'b0) begin
                n_err++;
                $display("FAIL %s cal sym %0d: sym=%h sv=%b ev=%b, want %h 1 0",
                         name, n, sym_out, sym_valid, err_valid, exp_sym);
            end
        end
        n_vec++;
        if (threshold !== 18'(want_thr) || threshold !== 18'(m_thr) || cal_done !== 1'b1) begin
            n_err++;
            $display("FAIL %s calibration: thr=%0d cal=%b, want %0d 1", name, threshold, cal_done, want_thr);
        end
        seq_mode = 0;
        wins = 0;
        for (int n = 0; n < n_run; n++) begin
            gen(i, q, r);
            step(i, q, r, 1'b0);
            if (exp_ev) wins++;
            n_vec++;
            if (err_valid !== exp_ev || sym_out !== exp_sym || (exp_ev && err_count !== 11'(m_errcnt))) begin
                n_err++;
                $display("FAIL %s run sym %0d: ev=%b cnt=%0d sym=%h, want ev=%b cnt=%0d sym=%h",
                         name, n, err_valid, err_count, sym_out, exp_ev, m_errcnt, exp_sym);
            end
        end
        n_vec++;
        if (wins != n_run / 1024 || threshold !== 18'(want_thr)) begin
            n_err++;
            $display("FAIL %s windows: seen=%0d thr=%0d, want %0d %0d", name, wins, threshold, n_run / 1024, want_thr);
        end
    endtask

    task automatic test_loopback();
        scale_sh = 0; inv_every = 0;
        run_loopback("loopback", 65536, 2048);
    endtask

    task automatic test_scaled();
        scale_sh = 1; inv_every = 0;
        run_loopback("scaled", 32768, 1024);
        scale_sh = 0;
    endtask

    task automatic test_inverted();
        inv_every = 16;
        run_loopback("inverted", 65536, 2048);
        n_vec++;
        if (err_count !== 11'd64) begin
            n_err++;
            $display("FAIL inverted count: got %0d, want 64", err_count);
        end
        inv_every = 0;
    endtask

    task automatic test_recal_reset();
        logic signed [17:0] i, q;
        logic [3:0] r;
        int ev_seen;
        run_loopback("pre_recal", 65536, 500);
        gen(i, q, r);
        step(i, q, r, 1'b1);
        n_vec++;
        if (cal_done !== 1'b0 || err_valid !== 1'b0) begin
            n_err++;
            $display("FAIL recal entry: cal=%b ev=%b, want 0 0", cal_done, err_valid);
        end
        ev_seen = 0;
        for (int n = 0; n < 256 + 1024; n++) begin
            gen(i, q, r);
            step(i, q, r, 1'b0);
            if (err_valid === 1'b1) ev_seen++;
            n_vec++;
            if (cal_done !== m_cal || err_valid !== exp_ev || (exp_ev && err_count !== 11'(m_errcnt))) begin
                n_err++;
                $display("FAIL recal sym %0d: cal=%b ev=%b cnt=%0d, want cal=%b ev=%b cnt=%0d",
                         n, cal_done, err_valid, err_count, m_cal, exp_ev, m_errcnt);
            end
        end
        n_vec++;
        if (ev_seen != 1) begin
            n_err++;
            $display("FAIL recal window: err_valid pulses=%0d, want 1", ev_seen);
        end
        for (int n = 0; n < 300; n++) begin
            gen(i, q, r);
            step(i, q, r, 1'b0);
        end
        @(negedge clk);
        reset = 1;
        repeat (3) @(negedge clk);
        #1;
        n_vec++;
        if (threshold !== 18'd65536 || sym_out !== 4'd0 || cal_done !== 1'b0 ||
            err_count !== 11'd0 || sym_valid !== 1'b0 || err_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset mid-run: thr=%0d sym=%h cal=%b cnt=%0d sv=%b ev=%b, want 65536 0 0 0 0 0",
                     threshold, sym_out, cal_done, err_count, sym_valid, err_valid);
        end
        reset = 0;
    endtask

    task automatic test_hold();
        logic [3:0] s0;
        logic [17:0] t0;
        logic [10:0] c0;
        logic       d0;
        run_loopback("pre_hold", 65536, 1024);
        s0 = sym_out; t0 = threshold; c0 = err_count; d0 = cal_done;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            in_phs_sig = 18'($urandom); quad_sig = 18'($urandom); ref_sym = 4'($urandom);
            @(posedge clk);
            #1;
            n_vec++;
            if (sym_out !== s0 || threshold !== t0 || err_count !== c0 || cal_done !== d0 ||
                sym_valid !== 1'b0 || err_valid !== 1'b0) begin
                n_err++;
                $display("FAIL hold cycle %0d: sym=%h thr=%0d cnt=%0d cal=%b sv=%b ev=%b, want %h %0d %0d %b 0 0",
                         n, sym_out, threshold, err_count, cal_done, sym_valid, err_valid, s0, t0, c0, d0);
            end
        end
    endtask

    initial begin
        reset = 1; sym_clk_en = 0; recal = 0;
        in_phs_sig = '0; quad_sig = '0; ref_sym = '0;
        test_reset();
        test_boundary();
        test_loopback();
        test_scaled();
        test_inverted();
        test_recal_reset();
        test_hold();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
